// File: rtl/i2c_vector_sequencer.sv
// Turns START/WRITE/READ/STOP commands into per-cycle tester vectors: an SCL
// waveform code and an SDA waveform code, each phase held for PHASE_CYCLES cycles.
module i2c_vector_sequencer #(
    parameter int WFT_ID       = 0,
    parameter int PHASE_CYCLES = 1
) (
    input  logic        tester_sync,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_ack,
    output logic [0:3]  wft,
    output logic [0:15] wfc,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_dbg
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_op/cmd_data/cmd_ack are sampled only then, and the producer may hold
    // cmd_valid high across back-to-back commands.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BITS  = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;
    localparam logic [7:0] SUB_LAST = 8'(PHASE_CYCLES - 1);

    localparam logic [7:0] SCL_LO  = 8'd1;
    localparam logic [7:0] SCL_HI  = 8'd2;
    localparam logic [7:0] SDA_LO  = 8'd1;
    localparam logic [7:0] SDA_HI  = 8'd2;
    localparam logic [7:0] SDA_CL  = 8'd3;
    localparam logic [7:0] SDA_CH  = 8'd4;
    localparam logic [7:0] SDA_REL = 8'd5;

    state_t      state, state_n;
    logic [1:0]  phase, phase_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  sub, sub_n;
    logic [1:0]  op_q, op_n;
    logic [7:0]  data_q, data_n;
    logic        ack_q, ack_n;

    logic        phase_end;
    logic        cmd_end;
    logic        accept;
    logic        emitting;
    logic        cur_bit;
    logic [7:0]  scl;
    logic [7:0]  sda;

    always_ff @(posedge tester_sync) begin
        if (reset) begin
            state   <= S_IDLE;
            phase   <= 2'd0;
            bit_idx <= 3'd0;
            sub     <= 8'd0;
            op_q    <= 2'd0;
            data_q  <= 8'd0;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_idx <= bit_idx_n;
            sub     <= sub_n;
            op_q    <= op_n;
            data_q  <= data_n;
            ack_q   <= ack_n;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        bit_idx_n = bit_idx;
        sub_n     = sub;
        op_n      = op_q;
        data_n    = data_q;
        ack_n     = ack_q;

        phase_end = (sub == SUB_LAST);
        cmd_end   = phase_end && (phase == 2'd3) &&
                    (state == S_START || state == S_STOP || state == S_ACK);
        // Ready on the final cycle lets the next command start with no gap.
        cmd_ready = !reset && (state == S_IDLE || cmd_end);
        accept    = cmd_valid && cmd_ready;

        if (accept) begin
            op_n      = cmd_op;
            data_n    = cmd_data;
            ack_n     = cmd_ack;
            phase_n   = 2'd0;
            sub_n     = 8'd0;
            bit_idx_n = 3'd7;
            case (cmd_op)
                OP_START: state_n = S_START;
                OP_STOP:  state_n = S_STOP;
                default:  state_n = S_BITS;
            endcase
        end else if (state != S_IDLE) begin
            if (phase_end) begin
                sub_n   = 8'd0;
                phase_n = phase + 2'd1;
                if (phase == 2'd3) begin
                    if (state == S_BITS) begin
                        if (bit_idx == 3'd0) state_n = S_ACK;
                        else                 bit_idx_n = bit_idx - 3'd1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end else begin
                sub_n = sub + 8'd1;
            end
        end
    end

    always_comb begin
        scl     = 8'd0;
        sda     = 8'd0;
        cur_bit = data_q[bit_idx];
        case (state)
            S_START: begin
                scl = (phase == 2'd3) ? SCL_LO : SCL_HI;
                sda = phase[1] ? SDA_LO : SDA_HI;
            end
            S_STOP: begin
                scl = (phase == 2'd0) ? SCL_LO : SCL_HI;
                sda = phase[1] ? SDA_HI : SDA_LO;
            end
            S_BITS: begin
                scl = (phase == 2'd1 || phase == 2'd2) ? SCL_HI : SCL_LO;
                if (op_q == OP_READ)
                    sda = (phase == 2'd2) ? (cur_bit ? SDA_CH : SDA_CL) : SDA_REL;
                else
                    sda = cur_bit ? SDA_HI : SDA_LO;
            end
            S_ACK: begin
                scl = (phase == 2'd1 || phase == 2'd2) ? SCL_HI : SCL_LO;
                if (op_q == OP_READ)
                    sda = ack_q ? SDA_HI : SDA_LO;
                else
                    sda = (phase == 2'd2) ? (ack_q ? SDA_CH : SDA_CL) : SDA_REL;
            end
            default: begin
                scl = 8'd0;
                sda = 8'd0;
            end
        endcase

        emitting  = (state != S_IDLE) && !reset;
        wfc       = emitting ? {scl, sda} : 16'd0;
        wft       = emitting ? 4'(WFT_ID) : 4'd0;
        busy      = emitting;
        done      = emitting && cmd_end;
        state_dbg = state;
    end

endmodule
